// File: rtl/uart_tx_arbiter_if.sv
// Shared UART transmit path bundle: requester byte streams in,
// single UART write port out, plus grant/status observability.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   last;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              abort_tick;
    logic              tx_full;
    logic              wr_uart;
    logic [7:0]        w_data;

    // Arbiter side
    modport slave (
        input  req, last, data, tx_full,
        output ack, grant, busy, abort_tick, wr_uart, w_data
    );

    // Requester / UART environment side
    modport master (
        output req, last, data, tx_full,
        input  ack, grant, busy, abort_tick, wr_uart, w_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one UART TX write port among
// NREQ byte-stream requesters, with a stall watchdog on the current owner.
module uart_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1000,
    parameter int TW      = 10
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]      state;
    logic [NREQ-1:0] grant_q;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_grant;
    logic [TW-1:0]   stall_cnt;
    logic            busy_q;
    logic            abort_q;

    logic            req_g;
    logic            last_g;
    logic [7:0]      byte_g;
    logic            wr;
    logic            any_req;
    logic [IW-1:0]   winner;

    always_comb begin
        req_g  = bus.req[owner];
        last_g = bus.last[owner];
        byte_g = bus.data[8*owner +: 8];
        wr     = (state == XFER) && req_g && !bus.tx_full;
    end

    // Cyclic search starting just after the previous owner, so the requester
    // that just finished is considered last.
    always_comb begin : rr_pick
        logic [IW-1:0] idx;
        idx     = '0;
        winner  = last_grant;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IW'((32'(last_grant) + k) % NREQ);
            if (!any_req && bus.req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    assign bus.wr_uart    = wr;
    assign bus.w_data     = (state == XFER) ? byte_g : 8'h00;
    assign bus.ack        = wr ? (NREQ'(1) << owner) : '0;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.abort_tick = abort_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant_q    <= '0;
            owner      <= '0;
            last_grant <= IW'(NREQ - 1);
            stall_cnt  <= '0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= XFER;
                        owner     <= winner;
                        grant_q   <= NREQ'(1) << winner;
                        busy_q    <= 1'b1;
                        stall_cnt <= '0;
                    end
                end
                XFER: begin
                    if (wr) begin
                        if (last_g) begin
                            state      <= IDLE;
                            grant_q    <= '0;
                            busy_q     <= 1'b0;
                            last_grant <= owner;
                        end else begin
                            stall_cnt <= '0;
                        end
                    end else if (!req_g) begin
                        // Back-pressure (req high, tx_full high) leaves the counter alone.
                        if (stall_cnt == TW'(TIMEOUT - 1)) begin
                            state      <= IDLE;
                            grant_q    <= '0;
                            busy_q     <= 1'b0;
                            last_grant <= owner;
                            abort_q    <= 1'b1;
                        end else begin
                            stall_cnt <= stall_cnt + TW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
